// File: rtl/jamma_pkg.sv
// Shared JAMMA bus definitions: bit positions, released level and scanner states.
package jamma_pkg;

    localparam int unsigned JAMMA_BITS = 8;

    localparam int unsigned UP    = 0;
    localparam int unsigned DOWN  = 1;
    localparam int unsigned LEFT  = 2;
    localparam int unsigned RIGHT = 3;
    localparam int unsigned FIRE1 = 4;
    localparam int unsigned FIRE2 = 5;
    localparam int unsigned FIRE3 = 6;
    localparam int unsigned START = 7;

    localparam logic [JAMMA_BITS-1:0] JOY_RELEASED = '1;

    typedef enum logic [1:0] {
        SELECT,
        SETTLE,
        SAMPLE
    } scan_state_t;

endpackage

// File: rtl/joy_debounce.sv
// One player's per-bit debouncer; a bit flips only after DEBOUNCE_SAMPLES
// consecutive strobed samples that disagree with the stable value.
module joy_debounce #(
    parameter int unsigned BITS             = 8,
    parameter int unsigned DEBOUNCE_SAMPLES = 1
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            strobe,
    input  logic [BITS-1:0] sample,
    output logic [BITS-1:0] stable
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);

    logic [CNT_W-1:0] cnt [BITS];

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '1;
            for (int i = 0; i < int'(BITS); i++) cnt[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < int'(BITS); i++) cnt[i] <= '0;
        end else if (strobe) begin
            for (int i = 0; i < int'(BITS); i++) begin
                if (sample[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] + CNT_W'(1) == CNT_W'(DEBOUNCE_SAMPLES)) begin
                    stable[i] <= sample[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/jamma_joy_scanner.sv
// Time-multiplexed JAMMA input scanner: selects each player bank in turn,
// waits for the external splitter to settle, then debounces that bank.
module jamma_joy_scanner
    import jamma_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS      = 2,
    parameter int unsigned BITS             = 8,
    parameter int unsigned SEL_W            = 1,
    parameter int unsigned SETTLE_CYCLES    = 0,
    parameter int unsigned DEBOUNCE_SAMPLES = 1,
    parameter int unsigned LOCAL_BITS       = 6
) (
    input  logic                        pclk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [BITS-1:0]             jjoy_in,
    input  logic [LOCAL_BITS-1:0]       local_joy,
    output logic [SEL_W-1:0]            jselect,
    output logic [NUM_PLAYERS*BITS-1:0] joy_out,
    output logic                        scan_done
);

    localparam int unsigned SETTLE_W = 8;

    scan_state_t         state, state_nxt;
    logic [SEL_W-1:0]    idx, idx_nxt;
    logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
    logic [SEL_W-1:0]    jselect_nxt;
    logic                scan_done_nxt;
    logic                last_c;
    logic                sample_c;
    logic                clr_c;
    logic [BITS-1:0]     raw_c;

    assign last_c   = (idx == SEL_W'(NUM_PLAYERS - 1));
    assign sample_c = en && (state == SAMPLE);
    assign clr_c    = !en;

    // Player 0 shares its directions/fires with the local DB9 stick.
    always_comb begin
        raw_c = jjoy_in;
        if (idx == '0) raw_c[LOCAL_BITS-1:0] = jjoy_in[LOCAL_BITS-1:0] & local_joy;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SELECT;
            idx        <= '0;
            settle_cnt <= '0;
            jselect    <= '0;
            scan_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            settle_cnt <= settle_nxt;
            jselect    <= jselect_nxt;
            scan_done  <= scan_done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        settle_nxt    = settle_cnt;
        jselect_nxt   = jselect;
        scan_done_nxt = 1'b0;
        if (!en) begin
            state_nxt  = SELECT;
            idx_nxt    = '0;
            settle_nxt = '0;
        end else begin
            case (state)
                SELECT: begin
                    jselect_nxt = idx;
                    settle_nxt  = SETTLE_W'(SETTLE_CYCLES);
                    state_nxt   = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
                end
                SETTLE: begin
                    if (settle_cnt <= SETTLE_W'(1)) begin
                        settle_nxt = '0;
                        state_nxt  = SAMPLE;
                    end else begin
                        settle_nxt = settle_cnt - SETTLE_W'(1);
                    end
                end
                SAMPLE: begin
                    idx_nxt       = last_c ? '0 : idx + SEL_W'(1);
                    scan_done_nxt = last_c;
                    state_nxt     = SELECT;
                end
                default: state_nxt = SELECT;
            endcase
        end
    end

    for (genvar p = 0; p < int'(NUM_PLAYERS); p++) begin : g_player
        logic strobe_c;
        assign strobe_c = sample_c && (idx == SEL_W'(p));

        joy_debounce #(
            .BITS             (BITS),
            .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
        ) u_debounce (
            .pclk   (pclk),
            .rst_n  (rst_n),
            .clr    (clr_c),
            .strobe (strobe_c),
            .sample (raw_c),
            .stable (joy_out[p*BITS +: BITS])
        );
    end

endmodule

// File: tb/tb_jamma_joy_scanner.sv
// Directed bench: four scanner configurations driven by small JAMMA bus models.
module tb_jamma_joy_scanner;

    logic pclk = 1'b0;
    logic rst_n;
    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A: defaults
    logic        en_a;
    logic [7:0]  bank_a [2];
    logic [5:0]  local_a;
    logic [7:0]  jjoy_a;
    logic [0:0]  jsel_a;
    logic [15:0] joy_a;
    logic        sd_a;
    assign jjoy_a = bank_a[jsel_a];

    jamma_joy_scanner u_a (
        .pclk(pclk), .rst_n(rst_n), .en(en_a), .jjoy_in(jjoy_a), .local_joy(local_a),
        .jselect(jsel_a), .joy_out(joy_a), .scan_done(sd_a)
    );

    // B: SETTLE_CYCLES=3, bus returns 0x00 for 3 cycles after a select change
    logic        en_b;
    logic [7:0]  bank_b [2];
    logic [5:0]  local_b;
    logic [7:0]  jjoy_b;
    logic [0:0]  jsel_b;
    logic [15:0] joy_b;
    logic        sd_b;
    logic [7:0]  age_b;
    logic [0:0]  prev_b;
    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            age_b  <= 8'hFF;
            prev_b <= 1'b0;
        end else begin
            prev_b <= jsel_b;
            if (jsel_b != prev_b) age_b <= 8'd1;
            else if (age_b != 8'hFF) age_b <= age_b + 8'd1;
        end
    end
    assign jjoy_b = (jsel_b == prev_b && age_b >= 8'd3) ? bank_b[jsel_b] : 8'h00;

    jamma_joy_scanner #(.SETTLE_CYCLES(3)) u_b (
        .pclk(pclk), .rst_n(rst_n), .en(en_b), .jjoy_in(jjoy_b), .local_joy(local_b),
        .jselect(jsel_b), .joy_out(joy_b), .scan_done(sd_b)
    );

    // C: DEBOUNCE_SAMPLES=3
    logic        en_c;
    logic [7:0]  bank_c [2];
    logic [5:0]  local_c;
    logic [7:0]  jjoy_c;
    logic [0:0]  jsel_c;
    logic [15:0] joy_c;
    logic        sd_c;
    assign jjoy_c = bank_c[jsel_c];

    jamma_joy_scanner #(.DEBOUNCE_SAMPLES(3)) u_c (
        .pclk(pclk), .rst_n(rst_n), .en(en_c), .jjoy_in(jjoy_c), .local_joy(local_c),
        .jselect(jsel_c), .joy_out(joy_c), .scan_done(sd_c)
    );

    // D: four players
    logic        en_d;
    logic [7:0]  bank_d [4];
    logic [5:0]  local_d;
    logic [7:0]  jjoy_d;
    logic [1:0]  jsel_d;
    logic [31:0] joy_d;
    logic        sd_d;
    assign jjoy_d = bank_d[jsel_d];

    jamma_joy_scanner #(.NUM_PLAYERS(4), .SEL_W(2)) u_d (
        .pclk(pclk), .rst_n(rst_n), .en(en_d), .jjoy_in(jjoy_d), .local_joy(local_d),
        .jselect(jsel_d), .joy_out(joy_d), .scan_done(sd_d)
    );

    // Garbage watch on B: each byte may only be released or its bank's real data
    logic mon_on = 1'b0;
    int   gerr = 0;
    always @(negedge pclk) begin
        if (mon_on) begin
            if (joy_b[7:0] != 8'hFF && joy_b[7:0] != bank_b[0]) gerr++;
            if (joy_b[15:8] != 8'hFF && joy_b[15:8] != bank_b[1]) gerr++;
        end
    end

    function automatic logic sd_of(input int w);
        case (w)
            0:       return sd_a;
            1:       return sd_b;
            2:       return sd_c;
            default: return sd_d;
        endcase
    endfunction

    // Cycles until the next observed scan_done pulse, or -1 on timeout
    task automatic wait_sd(input int w, input int budget, output int n);
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!sd_of(w) && n < budget);
        if (!sd_of(w)) n = -1;
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [5:0]  loc;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int         n;
        int         cnt;
        logic [3:0] pat;
        logic [9:0] seq;
        logic [1:0] last2;
        logic [0:0] last1;

        vecs[0] = '{8'hFE, 8'h7F, 6'h3F, 16'h7FFE};
        vecs[1] = '{8'hFF, 8'hFF, 6'h3D, 16'hFFFD};
        vecs[2] = '{8'h00, 8'hFF, 6'h3F, 16'hFF00};
        vecs[3] = '{8'hC3, 8'h3C, 6'h2A, 16'h3CC2};
        vecs[4] = '{8'hFF, 8'h00, 6'h00, 16'h00C0};

        rst_n = 1'b0;
        {en_a, en_b, en_c, en_d} = 4'hF;
        {local_a, local_b, local_c, local_d} = {4{6'h3F}};
        for (int i = 0; i < 2; i++) begin
            bank_a[i] = 8'h00; bank_b[i] = 8'h00; bank_c[i] = 8'h00;
        end
        for (int i = 0; i < 4; i++) bank_d[i] = 8'h00;

        repeat (3) @(negedge pclk);
        chk("reset_joy_a", 32'(joy_a), 32'h0000FFFF);
        chk("reset_jsel_a", 32'(jsel_a), 32'h0);
        chk("reset_sd_a", 32'(sd_a), 32'h0);
        chk("reset_joy_d", joy_d, 32'hFFFFFFFF);

        rst_n = 1'b1;
        bank_b[0] = 8'hA5; bank_b[1] = 8'h5A;
        bank_c[0] = 8'hFF; bank_c[1] = 8'hFF;
        bank_d[0] = 8'h11; bank_d[1] = 8'h22; bank_d[2] = 8'h33; bank_d[3] = 8'h44;
        mon_on = 1'b1;

        // A: table of bus patterns, each must land within one 4-cycle scan
        for (int i = 0; i < 5; i++) begin
            bank_a[0] = vecs[i].b0;
            bank_a[1] = vecs[i].b1;
            local_a   = vecs[i].loc;
            repeat (4) @(negedge pclk);
            chk($sformatf("vec%0d_joy_a", i), 32'(joy_a), 32'(vecs[i].exp));
        end

        wait_sd(0, 20, n);
        wait_sd(0, 20, n);
        chk("a_scan_period", n, 4);
        pat = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            pat = {pat[2:0], jsel_a};
        end
        chk("a_jsel_pattern", 32'(pat), 32'b0011);

        // B: slot of 5 cycles, scan of 10, garbage never visible
        wait_sd(1, 40, n);
        wait_sd(1, 40, n);
        chk("b_scan_period", n, 10);
        last1 = jsel_b;
        n = 0;
        while (jsel_b == last1 && n < 20) begin @(negedge pclk); n++; end
        last1 = jsel_b;
        n = 0;
        while (jsel_b == last1 && n < 20) begin @(negedge pclk); n++; end
        chk("b_slot_len", n, 5);
        repeat (20) @(negedge pclk);
        chk("b_joy", 32'(joy_b), 32'h00005AA5);
        chk("b_garbage", gerr, 0);

        // C: two low samples are a glitch, three are a press
        wait_sd(2, 20, n);
        bank_c[1] = 8'hEF;
        wait_sd(2, 20, n);
        wait_sd(2, 20, n);
        chk("c_two_low", 32'(joy_c[12]), 32'h1);
        bank_c[1] = 8'hFF;
        wait_sd(2, 20, n);
        wait_sd(2, 20, n);
        chk("c_after_glitch", 32'(joy_c[12]), 32'h1);
        bank_c[1] = 8'hEF;
        wait_sd(2, 20, n);
        wait_sd(2, 20, n);
        chk("c_second_low", 32'(joy_c[12]), 32'h1);
        wait_sd(2, 20, n);
        chk("c_third_low", 32'(joy_c[12]), 32'h0);
        chk("c_joy", 32'(joy_c), 32'h0000EFFF);

        // D: select sequence and scan_done cadence
        wait_sd(3, 40, n);
        last2 = jsel_d;
        seq = '0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (jsel_d == last2 && n < 20) begin @(negedge pclk); n++; end
            seq   = {seq[7:0], jsel_d};
            last2 = jsel_d;
        end
        chk("d_jsel_seq", 32'(seq), 32'b00_01_10_11_00);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge pclk);
            if (sd_d) cnt++;
        end
        chk("d_sd_count", cnt, 2);
        chk("d_joy", joy_d, 32'h44332211);

        // D: drop enable in bank 2's slot, then restart
        n = 0;
        while (jsel_d != 2'd2 && n < 20) begin @(negedge pclk); n++; end
        chk("d_reach_bank2", 32'(jsel_d), 32'h2);
        en_d = 1'b0;
        for (int i = 0; i < 4; i++) bank_d[i] = 8'h00;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge pclk);
            if (sd_d) cnt++;
        end
        chk("d_frozen_sd", cnt, 0);
        chk("d_frozen_joy", joy_d, 32'h44332211);
        bank_d[0] = 8'h81; bank_d[1] = 8'h82; bank_d[2] = 8'h83; bank_d[3] = 8'h84;
        en_d = 1'b1;
        @(negedge pclk);
        chk("d_restart_jsel0", 32'(jsel_d), 32'h0);
        chk("d_restart_hold", joy_d, 32'h44332211);
        @(negedge pclk);
        chk("d_restart_p0", joy_d, 32'h44332281);
        @(negedge pclk);
        chk("d_restart_jsel1", 32'(jsel_d), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
